// File: rtl/prio_enc_arb.sv
// Registered N-input priority encoder with sticky request latching, masking and a valid/ready output.
// Define PRIO_ENC_RR_EN for round-robin arbitration; the default is fixed highest-index-first priority.
module prio_enc_arb #(
  parameter int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic [N-1:0] mask,
  output logic [W-1:0] idx_o,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [N-1:0] pend_o
);

  logic [N-1:0] pend;
  logic [N-1:0] clr;
  logic [N-1:0] nxt_pend;
  logic [N-1:0] cand;
  logic         accept;
  logic         load;

`ifdef PRIO_ENC_RR_EN
  logic [W-1:0] last;
  logic [W-1:0] last_eff;

  // Search last-1, last-2, ... wrapping, ending at last; nearest hit wins.
  function automatic logic [W-1:0] pick(input logic [N-1:0] c, input logic [W-1:0] base);
    logic [W-1:0] win;
    win = '0;
    for (int k = N; k >= 1; k--) begin
      int j;
      j = (int'(base) + N - k) % N;
      if (c[j]) win = W'(j);
    end
    return win;
  endfunction
`else
  function automatic logic [W-1:0] pick(input logic [N-1:0] c);
    logic [W-1:0] win;
    win = '0;
    for (int j = 0; j < N; j++) begin
      if (c[j]) win = W'(j);
    end
    return win;
  endfunction
`endif

  assign accept = valid_o && ready_i;
  assign load   = !valid_o || ready_i;

  always_comb begin
    clr = '0;
    if (accept) clr[idx_o] = 1'b1;
  end

  // Set wins over clear so a re-request in the accepting cycle is never lost.
  assign nxt_pend = (pend & ~clr) | req;
  assign cand     = nxt_pend & mask;
  assign pend_o   = pend;

`ifdef PRIO_ENC_RR_EN
  // The accepting edge already counts as the new 'last' for the next pick.
  assign last_eff = accept ? idx_o : last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= '0;
    end else if (accept) begin
      last <= idx_o;
    end
  end
`endif

  // Pending register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
    end else begin
      pend <= nxt_pend;
    end
  end

  // Output stage: holds while presented and not accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_o <= 1'b0;
      idx_o   <= '0;
    end else if (load) begin
      valid_o <= |cand;
`ifdef PRIO_ENC_RR_EN
      idx_o   <= pick(cand, last_eff);
`else
      idx_o   <= pick(cand);
`endif
    end
  end

endmodule
